// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between instruction-fetch (0)
// and data-access (1) requesters; an ID FIFO steers each response back to its issuer.
module mem_req_arbiter #(
    parameter int p_depth = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_val,
    output logic        req0_rdy,
    input  logic        req0_type,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        resp0_val,
    output logic [31:0] resp0_data,

    input  logic        req1_val,
    output logic        req1_rdy,
    input  logic        req1_type,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        resp1_val,
    output logic [31:0] resp1_data,

    output logic        memreq_val,
    input  logic        memreq_rdy,
    output logic        memreq_type,
    output logic [31:0] memreq_addr,
    output logic [31:0] memreq_wdata,

    input  logic        memresp_val,
    input  logic [31:0] memresp_data
);

    localparam int PTR_W = $clog2(p_depth);
    localparam int CNT_W = PTR_W + 1;

    logic               last_q, last_d;
    logic [p_depth-1:0] ids_q, ids_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic full, empty, grant, sel, fire, pop, head_id;

    always_comb begin
        full  = (count_q == CNT_W'(p_depth));
        empty = (count_q == '0);

        // On a tie, favour whoever was not granted last.
        grant = (req0_val && req1_val) ? ~last_q : req1_val;

        // full is purely registered, so memreq_rdy never feeds memreq_val.
        memreq_val   = (req0_val | req1_val) & ~full & ~rst;
        sel          = memreq_val & grant;
        memreq_type  = sel ? req1_type  : req0_type;
        memreq_addr  = sel ? req1_addr  : req0_addr;
        memreq_wdata = sel ? req1_wdata : req0_wdata;

        req0_rdy = memreq_rdy & memreq_val & ~grant & req0_val;
        req1_rdy = memreq_rdy & memreq_val &  grant & req1_val;
        fire     = memreq_val & memreq_rdy;

        // Responses with nothing outstanding are dropped silently.
        head_id    = ids_q[head_q];
        pop        = memresp_val & ~empty & ~rst;
        resp0_val  = pop & ~head_id;
        resp1_val  = pop &  head_id;
        resp0_data = memresp_data;
        resp1_data = memresp_data;
    end

    always_comb begin
        last_d  = last_q;
        ids_d   = ids_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (fire) begin
            ids_d[tail_q] = grant;
            tail_d        = tail_q + PTR_W'(1);
            last_d        = grant;
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end

        if (fire && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!fire && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= 1'b1;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            last_q  <= last_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ID storage is only meaningful between head and tail, so it needs no reset.
    always_ff @(posedge clk) begin
        ids_q <= ids_d;
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus a randomized run
// against a queue-based model of outstanding requester ids.
module tb_mem_req_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_val, req0_rdy, req0_type;
    logic [31:0] req0_addr, req0_wdata;
    logic        resp0_val;
    logic [31:0] resp0_data;
    logic        req1_val, req1_rdy, req1_type;
    logic [31:0] req1_addr, req1_wdata;
    logic        resp1_val;
    logic [31:0] resp1_data;
    logic        memreq_val, memreq_rdy, memreq_type;
    logic [31:0] memreq_addr, memreq_wdata;
    logic        memresp_val;
    logic [31:0] memresp_data;

    mem_req_arbiter #(.p_depth(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_type(req0_type),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .resp0_val(resp0_val), .resp0_data(resp0_data),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_type(req1_type),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .resp1_val(resp1_val), .resp1_data(resp1_data),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
        .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
        .memresp_val(memresp_val), .memresp_data(memresp_data)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    // Model: ids of accepted-but-unanswered requests, oldest first.
    bit   mq[$];
    bit   m_last = 1'b1;
    logic e_mval, e_r0, e_r1, e_gnt, e_p0, e_p1;

    typedef struct {
        int          due;
        logic [31:0] data;
    } mrec_t;

    function automatic void model_eval();
        bit full;
        bit pop;
        e_mval = 0; e_r0 = 0; e_r1 = 0; e_gnt = 0; e_p0 = 0; e_p1 = 0;
        if (rst) return;
        full = (mq.size() == DEPTH);
        if (req0_val && req1_val) e_gnt = (m_last == 1'b0);
        else                      e_gnt = req1_val;
        e_mval = (req0_val || req1_val) && !full;
        e_r0   = e_mval && memreq_rdy && !e_gnt;
        e_r1   = e_mval && memreq_rdy && e_gnt;
        pop    = memresp_val && (mq.size() > 0);
        if (pop) begin
            e_p0 = (mq[0] == 1'b0);
            e_p1 = (mq[0] == 1'b1);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        model_eval();
    endtask

    task automatic commit();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_last = 1'b1;
        end else begin
            if (e_p0 || e_p1) void'(mq.pop_front());
            if (e_mval && memreq_rdy) begin
                mq.push_back(e_gnt);
                m_last = e_gnt;
            end
        end
        #1;
        cyc++;
    endtask

    task automatic set_idle();
        req0_val = 0; req0_type = 0; req0_addr = '0; req0_wdata = '0;
        req1_val = 0; req1_type = 0; req1_addr = '0; req1_wdata = '0;
        memreq_rdy = 1; memresp_val = 0; memresp_data = '0;
    endtask

    task automatic apply_reset();
        set_idle();
        rst = 1;
        tick();
        commit();
        rst = 0;
    endtask

    task automatic drain(input int n);
        set_idle();
        memresp_val = 1;
        for (int i = 0; i < n; i++) begin
            tick();
            commit();
        end
        set_idle();
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1; req0_val = 1; req1_val = 1; memresp_val = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            nchk++;
            if ({memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val} !== 5'b0) begin
                nerr++;
                $display("FAIL reset_outputs got=%b want=00000",
                         {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val});
            end
            commit();
        end
        rst = 0;
        set_idle();
        tick();
        nchk++;
        if (memreq_val !== 1'b0) begin nerr++; $display("FAIL reset_idle_memreq got=%b want=0", memreq_val); end
        commit();
    endtask

    task automatic test_single();
        apply_reset();
        req0_val = 1; req0_addr = 32'h100;
        tick();
        nchk++;
        if (memreq_val !== 1'b1) begin nerr++; $display("FAIL single_memreq_val got=%b want=1", memreq_val); end
        nchk++;
        if (memreq_addr !== 32'h100) begin nerr++; $display("FAIL single_addr got=%h want=00000100", memreq_addr); end
        nchk++;
        if (memreq_type !== 1'b0) begin nerr++; $display("FAIL single_type got=%b want=0", memreq_type); end
        nchk++;
        if ({req0_rdy, req1_rdy} !== 2'b10) begin nerr++; $display("FAIL single_rdy got=%b want=10", {req0_rdy, req1_rdy}); end
        commit();
        set_idle();
        memresp_val = 1; memresp_data = 32'hDEADBEEF;
        tick();
        nchk++;
        if ({resp0_val, resp1_val} !== 2'b10) begin nerr++; $display("FAIL single_resp_val got=%b want=10", {resp0_val, resp1_val}); end
        nchk++;
        if (resp0_data !== 32'hDEADBEEF) begin nerr++; $display("FAIL single_resp_data got=%h want=deadbeef", resp0_data); end
        commit();
        set_idle();
    endtask

    task automatic test_tie();
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            set_idle();
            req0_val = (k < 4); req0_addr = 32'h0;
            req1_val = (k < 4); req1_addr = 32'h4;
            memresp_val = (k >= 1); memresp_data = 32'hA000 + k;
            tick();
            if (k < 4) begin
                nchk++;
                if (memreq_addr !== ((k % 2) ? 32'h4 : 32'h0)) begin
                    nerr++; $display("FAIL tie_addr k=%0d got=%h want=%h", k, memreq_addr, (k % 2) ? 32'h4 : 32'h0);
                end
                nchk++;
                if ({req0_rdy, req1_rdy} !== ((k % 2) ? 2'b01 : 2'b10)) begin
                    nerr++; $display("FAIL tie_rdy k=%0d got=%b want=%b", k, {req0_rdy, req1_rdy}, (k % 2) ? 2'b01 : 2'b10);
                end
            end
            if (k >= 1) begin
                nchk++;
                if ({resp0_val, resp1_val} !== (((k - 1) % 2) ? 2'b01 : 2'b10)) begin
                    nerr++; $display("FAIL tie_resp k=%0d got=%b want=%b", k, {resp0_val, resp1_val}, ((k - 1) % 2) ? 2'b01 : 2'b10);
                end
            end
            commit();
        end
        set_idle();
    endtask

    task automatic test_backpressure();
        apply_reset();
        req0_val = 1; req0_addr = 32'h10;
        req1_val = 1; req1_addr = 32'h20;
        memreq_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nchk++;
            if ({memreq_val, req0_rdy, req1_rdy} !== 3'b100) begin
                nerr++; $display("FAIL bp_stall i=%0d got=%b want=100", i, {memreq_val, req0_rdy, req1_rdy});
            end
            nchk++;
            if (memreq_addr !== 32'h10) begin nerr++; $display("FAIL bp_addr got=%h want=00000010", memreq_addr); end
            commit();
        end
        memreq_rdy = 1;
        tick();
        nchk++;
        if ({req0_rdy, req1_rdy} !== 2'b10) begin nerr++; $display("FAIL bp_release got=%b want=10", {req0_rdy, req1_rdy}); end
        commit();
        set_idle();
        memresp_val = 1;
        tick();
        nchk++;
        if ({resp0_val, resp1_val} !== 2'b10) begin nerr++; $display("FAIL bp_resp got=%b want=10", {resp0_val, resp1_val}); end
        commit();
        tick();
        nchk++;
        if ({resp0_val, resp1_val} !== 2'b00) begin nerr++; $display("FAIL bp_empty_drop got=%b want=00", {resp0_val, resp1_val}); end
        commit();
        set_idle();
    endtask

    task automatic test_full();
        apply_reset();
        req0_val = 1; req0_addr = 32'h40;
        req1_val = 1; req1_addr = 32'h80;
        for (int k = 0; k < 4; k++) begin
            tick();
            nchk++;
            if (memreq_val !== 1'b1) begin nerr++; $display("FAIL full_fill k=%0d got=%b want=1", k, memreq_val); end
            commit();
        end
        tick();
        nchk++;
        if ({memreq_val, req0_rdy, req1_rdy} !== 3'b000) begin
            nerr++; $display("FAIL full_block got=%b want=000", {memreq_val, req0_rdy, req1_rdy});
        end
        commit();
        memresp_val = 1;
        tick();
        nchk++;
        if (memreq_val !== 1'b0) begin nerr++; $display("FAIL full_pop_cycle_val got=%b want=0", memreq_val); end
        nchk++;
        if ({resp0_val, resp1_val} !== 2'b10) begin nerr++; $display("FAIL full_first_resp got=%b want=10", {resp0_val, resp1_val}); end
        commit();
        memresp_val = 0;
        tick();
        nchk++;
        if ({memreq_val, req0_rdy} !== 2'b11) begin nerr++; $display("FAIL full_reopen got=%b want=11", {memreq_val, req0_rdy}); end
        commit();
        set_idle();
        memresp_val = 1;
        for (int j = 0; j < 4; j++) begin
            tick();
            nchk++;
            if ({resp0_val, resp1_val} !== ((j % 2) ? 2'b10 : 2'b01)) begin
                nerr++; $display("FAIL full_drain j=%0d got=%b want=%b", j, {resp0_val, resp1_val}, (j % 2) ? 2'b10 : 2'b01);
            end
            commit();
        end
        set_idle();
    endtask

    task automatic test_simul_push_pop();
        apply_reset();
        req0_val = 1; req0_addr = 32'h300;
        tick(); commit();
        tick(); commit();
        memresp_val = 1;
        tick();
        nchk++;
        if ({req0_rdy, resp0_val} !== 2'b11) begin nerr++; $display("FAIL simul_both got=%b want=11", {req0_rdy, resp0_val}); end
        commit();
        memresp_val = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            nchk++;
            if (memreq_val !== 1'b1) begin nerr++; $display("FAIL simul_refill k=%0d got=%b want=1", k, memreq_val); end
            commit();
        end
        tick();
        nchk++;
        if (memreq_val !== 1'b0) begin nerr++; $display("FAIL simul_count_full got=%b want=0", memreq_val); end
        commit();
        drain(4);
    endtask

    task automatic test_random();
        mrec_t       memq[$];
        logic [31:0] sb0[$];
        logic [31:0] sb1[$];
        logic [31:0] gaddr;
        int          done = 0;
        apply_reset();
        for (int c = 0; c < 600 && done < 20; c++) begin
            req0_val = 1'($urandom % 2); req0_type = 1'($urandom % 2);
            req0_addr = $urandom; req0_wdata = $urandom;
            req1_val = 1'($urandom % 2); req1_type = 1'($urandom % 2);
            req1_addr = $urandom; req1_wdata = $urandom;
            memreq_rdy = (($urandom % 4) != 0);
            memresp_val = 0; memresp_data = $urandom;
            if (memq.size() > 0 && memq[0].due <= cyc && ($urandom % 3) != 0) begin
                memresp_val = 1; memresp_data = memq[0].data;
            end
            tick();
            nchk++;
            if ({memreq_val, req0_rdy, req1_rdy} !== {e_mval, e_r0, e_r1}) begin
                nerr++; $display("FAIL rand_req c=%0d got=%b want=%b", c, {memreq_val, req0_rdy, req1_rdy}, {e_mval, e_r0, e_r1});
            end
            nchk++;
            if ({resp0_val, resp1_val} !== {e_p0, e_p1}) begin
                nerr++; $display("FAIL rand_resp c=%0d got=%b want=%b", c, {resp0_val, resp1_val}, {e_p0, e_p1});
            end
            gaddr = e_gnt ? req1_addr : req0_addr;
            if (e_mval) begin
                nchk++;
                if (memreq_addr !== gaddr) begin nerr++; $display("FAIL rand_addr c=%0d got=%h want=%h", c, memreq_addr, gaddr); end
            end
            if (e_p0 && sb0.size() > 0) begin
                nchk++;
                if (resp0_data !== sb0[0]) begin nerr++; $display("FAIL rand_data0 c=%0d got=%h want=%h", c, resp0_data, sb0[0]); end
                void'(sb0.pop_front());
            end
            if (e_p1 && sb1.size() > 0) begin
                nchk++;
                if (resp1_data !== sb1[0]) begin nerr++; $display("FAIL rand_data1 c=%0d got=%h want=%h", c, resp1_data, sb1[0]); end
                void'(sb1.pop_front());
            end
            if (memresp_val) begin
                void'(memq.pop_front());
                done++;
            end
            if (e_mval && memreq_rdy) begin
                memq.push_back('{due: cyc + 1 + int'($urandom % 4), data: gaddr ^ 32'hC0DE0000});
                if (e_gnt) sb1.push_back(gaddr ^ 32'hC0DE0000);
                else       sb0.push_back(gaddr ^ 32'hC0DE0000);
            end
            commit();
        end
        nchk++;
        if (done < 20) begin nerr++; $display("FAIL rand_timeout got=%0d want=20 responses", done); end
        set_idle();
        while (memq.size() > 0) begin
            memresp_val = 1; memresp_data = memq[0].data;
            tick();
            nchk++;
            if ({resp0_val, resp1_val} !== {e_p0, e_p1}) begin
                nerr++; $display("FAIL rand_drain got=%b want=%b", {resp0_val, resp1_val}, {e_p0, e_p1});
            end
            void'(memq.pop_front());
            commit();
        end
        set_idle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req0_val = 1; req0_addr = 32'h500;
        for (int k = 0; k < 3; k++) begin
            tick(); commit();
        end
        rst = 1; req1_val = 1;
        tick();
        nchk++;
        if ({memreq_val, req0_rdy, req1_rdy} !== 3'b000) begin
            nerr++; $display("FAIL midrst_outputs got=%b want=000", {memreq_val, req0_rdy, req1_rdy});
        end
        commit();
        rst = 0;
        set_idle();
        memresp_val = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            nchk++;
            if ({resp0_val, resp1_val} !== 2'b00) begin nerr++; $display("FAIL midrst_late_resp k=%0d got=%b want=00", k, {resp0_val, resp1_val}); end
            commit();
        end
        set_idle();
        req1_val = 1; req1_type = 1; req1_addr = 32'h200; req1_wdata = 32'h12345678;
        tick();
        nchk++;
        if ({memreq_val, memreq_type, req1_rdy} !== 3'b111) begin
            nerr++; $display("FAIL midrst_write_ctl got=%b want=111", {memreq_val, memreq_type, req1_rdy});
        end
        nchk++;
        if ({memreq_addr, memreq_wdata} !== {32'h200, 32'h12345678}) begin
            nerr++; $display("FAIL midrst_write_data got=%h_%h want=00000200_12345678", memreq_addr, memreq_wdata);
        end
        commit();
        req0_val = 1; req0_addr = 32'h600; memresp_val = 1;
        tick();
        nchk++;
        if ({req0_rdy, req1_rdy, resp1_val} !== 3'b101) begin
            nerr++; $display("FAIL midrst_tie got=%b want=101", {req0_rdy, req1_rdy, resp1_val});
        end
        commit();
        set_idle();
        memresp_val = 1;
        tick();
        nchk++;
        if ({resp0_val, resp1_val} !== 2'b10) begin nerr++; $display("FAIL midrst_final_resp got=%b want=10", {resp0_val, resp1_val}); end
        commit();
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1;
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_full();
        test_simul_push_pop();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation did not complete");
    end

endmodule
